// File: rtl/dmd_pkg.sv
// Shared types and helpers for the DMD frame writer.
// Optional DMD_MIRROR_EN: horizontal flip of the column field of the buffer address.
package dmd_pkg;

   localparam int DMD_COLS   = 128;
   localparam int DMD_ROWS   = 32;
   localparam int BUF_ADDR_W = 13;
   localparam int PIX_W      = 4;

`ifdef DMD_MIRROR_EN
   localparam bit MIRROR = 1'b1;
`else
   localparam bit MIRROR = 1'b0;
`endif

   typedef enum logic [1:0] {
      SYNC_WAIT,
      CAPTURE,
      OVERRUN
   } state_t;

   // Buffer address is {row, column field}; the column field is flipped for rear-mounted panels.
   function automatic logic [BUF_ADDR_W-1:0] compose_addr(input logic [5:0] row,
                                                           input logic [6:0] col,
                                                           input logic [6:0] last_col);
      logic [6:0] col_field;
      col_field = MIRROR ? (last_col - col) : col;
      return {row, col_field};
   endfunction

endpackage

// File: rtl/dmd_frame_writer_if.sv
// Screen buffer port A write bus: the frame writer drives it, the buffer receives it.
interface dmd_frame_writer_if;
   import dmd_pkg::*;

   logic                  wr_en;
   logic [BUF_ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]      wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/dmd_sync_edge.sv
// Synchroniser for an async strobe and its companion data bit, with a rising-edge
// pulse on the strobe; both bits see the same delay so the data lines up with the pulse.
module dmd_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_in,
   input  logic data_in,
   output logic strobe_rise,
   output logic data_sync
);

   logic [STAGES-1:0] strobe_sr;
   logic [STAGES-1:0] data_sr;
   logic              strobe_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_sr   <= '0;
         data_sr     <= '0;
         strobe_prev <= 1'b0;
      end else begin
         strobe_sr   <= {strobe_sr[STAGES-2:0], strobe_in};
         data_sr     <= {data_sr[STAGES-2:0], data_in};
         strobe_prev <= strobe_sr[STAGES-1];
      end
   end

   assign strobe_rise = strobe_sr[STAGES-1] & ~strobe_prev;
   assign data_sync   = data_sr[STAGES-1];

endmodule

// File: rtl/dmd_frame_writer.sv
// Captures the serial DMD dot stream and writes 4-bit pixels into the screen buffer.
// Optional DMD_MIRROR_EN (see dmd_pkg): mirrors the column field of wr_addr.
module dmd_frame_writer
   import dmd_pkg::*;
#(
   parameter int           COLS        = DMD_COLS,
   parameter int           ROWS        = DMD_ROWS,
   parameter logic [3:0]   ON_LEVEL    = 4'd15,
   parameter int           SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dmd_dotclk,
   input  logic                dmd_data,
   input  logic                dmd_rowclk,
   input  logic                dmd_rowdata,
   dmd_frame_writer_if.master  wr,
   output logic                frame_done,
   output logic                locked,
   output logic                err_overflow
);

   localparam logic [7:0] COLS_W   = 8'(COLS);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   logic [1:0] rst_sr;
   logic       rst_n_i;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sr <= 2'b00;
      else        rst_sr <= {rst_sr[0], 1'b1};
   end
   assign rst_n_i = rst_sr[1];

   logic dot_rise, dot_data, row_rise, row_mark;

   dmd_sync_edge #(.STAGES(SYNC_STAGES)) u_dot_sync (
      .clk         (clk),
      .rst_n       (rst_n_i),
      .strobe_in   (dmd_dotclk),
      .data_in     (dmd_data),
      .strobe_rise (dot_rise),
      .data_sync   (dot_data)
   );

   dmd_sync_edge #(.STAGES(SYNC_STAGES)) u_row_sync (
      .clk         (clk),
      .rst_n       (rst_n_i),
      .strobe_in   (dmd_rowclk),
      .data_in     (dmd_rowdata),
      .strobe_rise (row_rise),
      .data_sync   (row_mark)
   );

   state_t                state_q, state_n;
   logic [5:0]            row_q, row_n;
   logic [7:0]            col_q, col_n;
   logic                  wr_en_q, wr_en_n;
   logic [BUF_ADDR_W-1:0] wr_addr_q, wr_addr_n;
   logic [PIX_W-1:0]      wr_data_q, wr_data_n;
   logic                  fd_q, fd_n;
   logic                  err_q, err_n;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= SYNC_WAIT;
         row_q     <= '0;
         col_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         fd_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         row_q     <= row_n;
         col_q     <= col_n;
         wr_en_q   <= wr_en_n;
         wr_addr_q <= wr_addr_n;
         wr_data_q <= wr_data_n;
         fd_q      <= fd_n;
         err_q     <= err_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_n   = state_q;
      row_n     = row_q;
      col_n     = col_q;
      wr_en_n   = 1'b0;
      wr_addr_n = wr_addr_q;
      wr_data_n = wr_data_q;
      fd_n      = 1'b0;
      err_n     = err_q;

      // Dot is handled first so a coincident row edge still writes to the old row/col.
      if (state_q == CAPTURE && dot_rise) begin
         if (col_q < COLS_W) begin
            wr_en_n   = 1'b1;
            wr_addr_n = compose_addr(row_q, col_q[6:0], LAST_COL);
            wr_data_n = dot_data ? ON_LEVEL : '0;
            col_n     = col_q + 8'd1;
         end else begin
            err_n = 1'b1;
         end
      end

      if (row_rise) begin
         if (row_mark) begin
            if (state_q == CAPTURE && row_q == LAST_ROW) fd_n = 1'b1;
            state_n = CAPTURE;
            row_n   = '0;
            col_n   = '0;
            err_n   = 1'b0;
         end else if (state_q == CAPTURE) begin
            if (row_q == LAST_ROW) begin
               fd_n    = 1'b1;
               state_n = OVERRUN;
            end else begin
               row_n = row_q + 6'd1;
               col_n = '0;
            end
         end else if (state_q == OVERRUN) begin
            err_n = 1'b1;
         end
      end
   end

   assign wr.wr_en     = wr_en_q;
   assign wr.wr_addr   = wr_addr_q;
   assign wr.wr_data   = wr_data_q;
   assign frame_done   = fd_q;
   assign locked       = (state_q == CAPTURE);
   assign err_overflow = err_q;

endmodule

// File: tb/tb_dmd_frame_writer.sv
// Directed self-checking bench for dmd_frame_writer; expected writes come from a
// scoreboard queue filled by the stimulus tasks.
module tb_dmd_frame_writer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dotclk = 1'b0, data = 1'b0, rowclk = 1'b0, rowdata = 1'b0;
   logic frame_done, locked, err_overflow;

   dmd_frame_writer_if wif();

   dmd_frame_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dmd_dotclk   (dotclk),
      .dmd_data     (data),
      .dmd_rowclk   (rowclk),
      .dmd_rowdata  (rowdata),
      .wr           (wif),
      .frame_done   (frame_done),
      .locked       (locked),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0] a;
      logic [3:0]  d;
   } wr_t;

   wr_t         exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   int          fd_cnt = 0;
   int unsigned cyc = 0;
   int unsigned t0 = 0;
   bit          measure = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [12:0] exp_addr(input int r, input int c);
`ifdef DMD_MIRROR_EN
      return 13'(r * 128 + (127 - c));
`else
      return 13'(r * 128 + c);
`endif
   endfunction

   // Output monitor, sampling on the falling edge.
   always @(negedge clk) begin
      wr_t e;
      if (frame_done) fd_cnt++;
      if (wif.wr_en) begin
         wr_cnt++;
         if (measure) begin
            check("first_wr_latency", 32'(cyc - t0), 32'd3);
            measure = 1'b0;
         end
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'(wif.wr_en), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(wif.wr_addr), 32'(e.a));
            check("wr_data", 32'(wif.wr_data), 32'(e.d));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dot(input logic d, input logic expect_wr, input int r, input int c);
      if (expect_wr) exp_q.push_back(wr_t'{a: exp_addr(r, c), d: (d ? 4'd15 : 4'd0)});
      data   = d;
      dotclk = 1'b1;
      tick(2);
      dotclk = 1'b0;
      tick(2);
   endtask

   task automatic row_pulse(input logic mark);
      rowdata = mark;
      rowclk  = 1'b1;
      tick(2);
      rowclk  = 1'b0;
      rowdata = 1'b0;
      tick(2);
   endtask

   initial begin
      int fd0;

      tick(3);
      check("rst_wr_en",      32'(wif.wr_en),      32'd0);
      check("rst_wr_addr",    32'(wif.wr_addr),    32'd0);
      check("rst_wr_data",    32'(wif.wr_data),    32'd0);
      check("rst_frame_done", 32'(frame_done),     32'd0);
      check("rst_locked",     32'(locked),         32'd0);
      check("rst_err",        32'(err_overflow),   32'd0);
      rst_n = 1'b1;
      tick(3);

      // Dots before any marker are ignored.
      repeat (5) dot(1'b1, 1'b0, 0, 0);
      check("nolock_locked", 32'(locked), 32'd0);
      check("nolock_writes", 32'(wr_cnt), 32'd0);

      // Full frame: row 0 alternates 1,0; later rows use a mod-3 pattern.
      row_pulse(1'b1);
      check("marker_locked", 32'(locked), 32'd1);
      measure = 1'b1;
      t0 = cyc;
      for (int c = 0; c < 128; c++) dot(c % 2 == 0, 1'b1, 0, c);
      check("row0_writes", 32'(wr_cnt), 32'd128);
      for (int r = 1; r < 32; r++) begin
         row_pulse(1'b0);
         for (int c = 0; c < 128; c++) dot((r + c) % 3 == 0, 1'b1, r, c);
      end
      check("frame_last_addr", 32'(wif.wr_addr), 32'(exp_addr(31, 127)));
      fd0 = fd_cnt;
      row_pulse(1'b0);
      check("frame_done_pulse", 32'(fd_cnt - fd0), 32'd1);
      check("overrun_locked",   32'(locked),       32'd0);
      check("frame_err",        32'(err_overflow), 32'd0);
      check("frame_writes",     32'(wr_cnt),       32'd4096);
      check("frame_q_empty",    32'(exp_q.size()), 32'd0);

      // OVERRUN: dots ignored, extra row sets the error, marker clears it.
      dot(1'b1, 1'b0, 0, 0);
      dot(1'b1, 1'b0, 0, 0);
      row_pulse(1'b0);
      check("overrun_row_err", 32'(err_overflow), 32'd1);
      row_pulse(1'b1);
      check("overrun_mark_err",    32'(err_overflow), 32'd0);
      check("overrun_mark_locked", 32'(locked),       32'd1);
      check("overrun_no_writes",   32'(wr_cnt),       32'd4096);

      // 130 dots in row 5: only 128 written, then the error flag.
      repeat (5) row_pulse(1'b0);
      for (int c = 0; c < 130; c++) dot(c % 2 == 1, c < 128, 5, c);
      check("dot_ovf_err",     32'(err_overflow), 32'd1);
      check("dot_ovf_q_empty", 32'(exp_q.size()), 32'd0);
      row_pulse(1'b1);
      check("dot_ovf_clear", 32'(err_overflow), 32'd0);

      // Coincident dot and row edge at row 3, col 10.
      repeat (3) row_pulse(1'b0);
      for (int c = 0; c < 10; c++) dot(1'b1, 1'b1, 3, c);
      exp_q.push_back(wr_t'{a: exp_addr(3, 10), d: 4'd15});
      data    = 1'b1;
      rowdata = 1'b0;
      dotclk  = 1'b1;
      rowclk  = 1'b1;
      tick(2);
      dotclk  = 1'b0;
      rowclk  = 1'b0;
      tick(2);
      dot(1'b0, 1'b1, 4, 0);
      check("coincident_q_empty", 32'(exp_q.size()), 32'd0);

      // Marker while the last row is open also ends the frame.
      row_pulse(1'b1);
      repeat (31) row_pulse(1'b0);
      fd0 = fd_cnt;
      row_pulse(1'b1);
      check("mark_last_row_fd",     32'(fd_cnt - fd0), 32'd1);
      check("mark_last_row_locked", 32'(locked),       32'd1);
      check("mark_last_row_err",    32'(err_overflow), 32'd0);

      tick(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmd_frame_writer.md
Name: dmd_frame_writer

Overview:
- Captures the serial pinball DMD stream: dot clock, dot data, row clock and first-row marker.
- Converts each captured dot to a 4-bit brightness word.
- Writes the words into port A of the 8192x4 dual-port screen buffer; the screen generator reads the same buffer on port B.
- Runs on the single system clock; all DMD inputs are asynchronous and are synchronised internally.

Parameters:
- COLS, 128, dots per row; address stride.
- ROWS, 32, rows per frame (1..64).
- ON_LEVEL, 4'd15, brightness written for a lit dot; an unlit dot writes 4'd0.
- SYNC_STAGES, 2, synchroniser depth (≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dmd_dotclk  in  1  DMD dot clock, async; data valid on rising edge.
- dmd_data  in  1  DMD serial dot data, async.
- dmd_rowclk  in  1  DMD row latch, async; rising edge closes the current row.
- dmd_rowdata  in  1  first-row marker, async; sampled at rowclk rise.
- wr_en  out  1  buffer port A write strobe, one clk per pixel.
- wr_addr  out  13  buffer address = row*128 + col.
- wr_data  out  4  pixel brightness.
- frame_done  out  1  one-clk pulse when row ROWS-1 closes.
- locked  out  1  high while in CAPTURE.
- err_overflow  out  1  sticky: excess dots or rows in the current frame.

Behaviour:
- Reset (async assert, sync deassert internal): wr_en=0, wr_addr=0, wr_data=0, frame_done=0, locked=0, err_overflow=0; col=0, row=0; state=SYNC_WAIT. Reset mid-row abandons the row; nothing is written until the next marker.
- Synchronisation: all four inputs pass through SYNC_STAGES flops. Rising edges of dotclk and rowclk are detected on the synchronised versions. Data and rowdata are sampled from their synchronised versions in the edge-detect cycle, so delays are matched.
- Latency: wr_en asserts exactly SYNC_STAGES+1 clk after a raw dotclk rise that meets setup; it is 3 clk at default.
- FSM states: SYNC_WAIT, CAPTURE, OVERRUN.
  - SYNC_WAIT: dot edges are ignored. A rowclk rise with rowdata=1 sets row=0, col=0 and goes to CAPTURE.
  - CAPTURE, dot edge with col<COLS: wr_en=1, wr_addr={row[5:0],col[6:0]}, wr_data=data?ON_LEVEL:0, then col+1.
  - CAPTURE, dot edge with col==COLS: no write, err_overflow=1.
  - CAPTURE, rowclk rise with rowdata=1: row=0, col=0 (resync; a short frame is allowed, no error).
  - CAPTURE, rowclk rise with rowdata=0: if row==ROWS-1, pulse frame_done and go to OVERRUN; else row+1, col=0.
  - OVERRUN: dots are ignored. A rowclk rise with rowdata=1 behaves as in SYNC_WAIT. A rowclk rise with rowdata=0 sets err_overflow=1.
- frame_done also pulses when a marker arrives while row==ROWS-1, i.e. the last row was filled but not closed.
- Simultaneous dot and row edges in one cycle: the dot is written to the old row/col first, then the row advances.
- err_overflow clears only on reset or on a marker received in CAPTURE/OVERRUN.
- Arithmetic: col is 8 bits and saturates at COLS. Row is 6 bits and never wraps. Address bit 12 is 0 when ROWS≤32.
- locked = (state==CAPTURE).

Optional Feature:
- Macro DMD_MIRROR_EN.
- Defined: the column field of wr_addr is COLS-1-col, giving a horizontal flip for rear-mounted panels.
- Undefined: the column field is col.
- All timing, flags and counters are identical either way.

Decomposition:
- Package dmd_pkg:
  - DMD_COLS=128, DMD_ROWS=32, BUF_ADDR_W=13, PIX_W=4.
  - State enum {SYNC_WAIT, CAPTURE, OVERRUN}.
  - Address-compose function.
- Sub-module dmd_sync_edge: SYNC_STAGES-flop synchroniser plus registered rising-edge pulse. It has reset to 0 and is instantiated for dotclk and rowclk. The data and rowdata inputs use its sync-only output.

Test Plan:
- Reset, then 5 dot clocks with data=1 and no marker -> wr_en never asserts, locked=0.
- Marker row, then 128 dots alternating 1,0 -> 128 writes at addresses 0..127. wr_data toggles 15,0. First wr_en 3 clk after the first raw dot edge.
- Full frame of 32 rows × 128 dots, then rowclk with rowdata=0 -> last write at addr 4095, frame_done single pulse, state OVERRUN, err_overflow=0.
- 130 dots in row 5 -> writes to 640..767 only, err_overflow=1. The next marker clears it.
- Dot and rowclk rising in the same clk at row 3, col 10 -> write to addr 394, then row=4, col=0.
- With DMD_MIRROR_EN: first dot of row 0 -> addr 127; dot col 5 of row 2 -> addr 378.
